pc_fetch_unit: RTL
==================

Name: pc_fetch_unit

Overview:
Owns the architectural PC register and drives instruction-memory fetch requests. It sits downstream of the next-PC select mux. It supplies pc_plus4 to the mux's sequential input and accepts the mux's taken-branch/jump target as redirect_pc. Fetched instructions are delivered to decode over a valid/ready handshake, and wrong-path fetches are flushed on redirect.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
XLEN, 32, address/instruction width

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
redirect  in  1  taken branch/jump this cycle (mux select != sequential)
redirect_pc  in  XLEN  target from next-PC mux; bits [1:0] ignored
pc_q  out  XLEN  current fetch PC
pc_plus4  out  XLEN  pc_q + 4, to next-PC mux sequential input
imem_req_valid  out  1  fetch request valid
imem_req_addr  out  XLEN  fetch address (= pc_q)
imem_req_ready  in  1  memory accepts request
imem_rsp_valid  in  1  instruction word returned (one per accepted request, in order)
imem_rsp_data  in  XLEN  instruction word
if_valid  out  1  instruction available to decode
if_instr  out  XLEN  buffered instruction
if_pc  out  XLEN  PC of if_instr
if_ready  in  1  decode accepts instruction

Behaviour:
- Reset (async assert, sync-released use): pc_q=RESET_PC with [1:0] forced 00; state=REQ; kill=0; if_valid=0; if_instr=0; if_pc=0; inflight_pc=0.
- pc_plus4 = pc_q + 4, modulo 2^XLEN; 32'hFFFF_FFFC wraps to 0. pc_q[1:0] is always 00.
- imem_req_valid = (state==REQ) && !redirect. imem_req_addr = pc_q. Request accepted when valid && ready.
- if_valid = (state==FULL).
- State REQ:
  - redirect: pc_q<=redirect_pc&~3; stay in REQ; no request issued.
  - Otherwise, on accept: inflight_pc<=pc_q; pc_q<=pc_plus4; go to WAIT.
  - imem_rsp_valid in REQ (stale response from before reset) is ignored.
- State WAIT:
  - rsp_valid && (kill || redirect): drop word; kill<=0; go to REQ. If redirect, also pc_q<=redirect_pc&~3.
  - rsp_valid otherwise: if_instr<=rsp_data; if_pc<=inflight_pc; go to FULL.
  - redirect without rsp_valid: kill<=1; pc_q<=redirect_pc&~3; stay in WAIT.
- State FULL:
  - redirect: discard buffer; pc_q<=redirect_pc&~3; go to REQ. Redirect beats if_ready in the same cycle, so no handshake completes.
  - Otherwise, if_ready: go to REQ.
  - Otherwise hold. if_instr and if_pc stay stable while if_valid=1 and no redirect.
- Latency: request issued in the cycle after entry to REQ is impossible; REQ issues combinationally the same cycle. With ready and a 1-cycle memory response, if_valid rises 2 cycles after the request is accepted. Peak throughput is 1 instruction per 3 cycles; no prefetch.
- At most one outstanding request. A new request is never issued while in WAIT.
- Multiple redirects in WAIT: the last redirect_pc wins; kill stays 1 until the response arrives.
- Reset mid-WAIT: the outstanding response is discarded by the REQ-state rule. The memory is reset on the same rst_n.

Test Plan:
1. Reset, RESET_PC=0, ready=1, 1-cycle memory returning addr-tagged words -> requests at 0x0, 0x4, 0x8; if_pc/if_instr match; pc_plus4=0x4 right after reset.
2. if_ready=0 for 5 cycles with FULL at if_pc=0x4 -> if_valid held, if_instr stable, imem_req_valid=0; after if_ready=1, next request addr=0x8.
3. Redirect to 0x100 in WAIT, response for 0x8 arrives 3 cycles later -> word dropped, if_valid stays 0, next request addr=0x100, if_pc=0x100.
4. Redirect to 0x203 concurrent with rsp_valid in WAIT -> word dropped, pc_q=0x200, request addr=0x200.
5. Redirect to 0x40 and if_ready=1 in the same FULL cycle -> no handshake counted, next request 0x40; redirect in REQ with req_ready=1 -> no accept, request addr=0x40 next cycle.
6. pc_q=0xFFFF_FFFC -> pc_plus4=0, next request addr=0x0. Assert rst_n=0 mid-WAIT -> pc_q=RESET_PC immediately and if_valid=0; a stale rsp_valid after release is ignored.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// PC register and single-outstanding instruction fetch, with a one-entry
// instruction buffer toward decode and wrong-path squashing on redirect.
module pc_fetch_unit #(
   parameter int unsigned         XLEN     = 32,
   parameter logic [XLEN-1:0]     RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            redirect,
   input  logic [XLEN-1:0] redirect_pc,
   output logic [XLEN-1:0] pc_q,
   output logic [XLEN-1:0] pc_plus4,
   output logic            imem_req_valid,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_req_ready,
   input  logic            imem_rsp_valid,
   input  logic [XLEN-1:0] imem_rsp_data,
   output logic            if_valid,
   output logic [XLEN-1:0] if_instr,
   output logic [XLEN-1:0] if_pc,
   input  logic            if_ready
);

   localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

   typedef enum logic [1:0] {
      ST_REQ  = 2'd0,
      ST_WAIT = 2'd1,
      ST_FULL = 2'd2
   } state_e;

   state_e          state_q, state_d;
   logic [XLEN-1:0] pc_d;
   logic            kill_q, kill_d;
   logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
   logic [XLEN-1:0] if_instr_q, if_instr_d;
   logic [XLEN-1:0] if_pc_q, if_pc_d;
   logic            req_fire;
   logic            rsp_keep;

   assign pc_plus4      = pc_q + XLEN'(4);
   assign imem_req_addr = pc_q;
   assign if_instr      = if_instr_q;
   assign if_pc         = if_pc_q;
   assign req_fire      = imem_req_valid && imem_req_ready;
   // A response is kept only if no redirect, current or earlier, has squashed it.
   assign rsp_keep      = (state_q == ST_WAIT) && imem_rsp_valid && !kill_q && !redirect;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_REQ;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      // NOTE: default first so no path leaves state_d unassigned (no latch).
      state_d = state_q;
      unique case (state_q)
         ST_REQ:  if (req_fire) state_d = ST_WAIT;
         ST_WAIT: if (imem_rsp_valid) state_d = rsp_keep ? ST_FULL : ST_REQ;
         ST_FULL: if (redirect || if_ready) state_d = ST_REQ;
         default: state_d = ST_REQ;
      endcase
   end

   // Output logic
   always_comb begin
      imem_req_valid = (state_q == ST_REQ) && !redirect;
      if_valid       = (state_q == ST_FULL);
   end

   // Datapath next values
   always_comb begin
      pc_d          = pc_q;
      kill_d        = kill_q;
      inflight_pc_d = inflight_pc_q;
      if_instr_d    = if_instr_q;
      if_pc_d       = if_pc_q;

      if (redirect) begin
         pc_d = redirect_pc & ALIGN_MASK;
      end else if (req_fire) begin
         pc_d          = pc_plus4;
         inflight_pc_d = pc_q;
      end

      if (state_q == ST_WAIT) begin
         if (imem_rsp_valid) begin
            kill_d = 1'b0;
         end else if (redirect) begin
            kill_d = 1'b1;
         end
      end

      if (rsp_keep) begin
         if_instr_d = imem_rsp_data;
         if_pc_d    = inflight_pc_q;
      end
   end

   // NOTE: every datapath flop, buffer included, is reset so if_* start at a known 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q          <= RESET_PC & ALIGN_MASK;
         kill_q        <= 1'b0;
         inflight_pc_q <= '0;
         if_instr_q    <= '0;
         if_pc_q       <= '0;
      end else begin
         pc_q          <= pc_d;
         kill_q        <= kill_d;
         inflight_pc_q <= inflight_pc_d;
         if_instr_q    <= if_instr_d;
         if_pc_q       <= if_pc_d;
      end
   end

endmodule
